// File: rtl/mem_subword_ctrl_pkg.sv
// Shared types and helpers for the data-memory sub-word access controller.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RMW,
        LOAD
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_WORD,
        SZ_HALF,
        SZ_BYTE
    } mem_size_t;

    // A set byte flag wins over the halfword flag.
    function automatic mem_size_t decode_size(input logic b, input logic half);
        if (b)
            return SZ_BYTE;
        else if (half)
            return SZ_HALF;
        return SZ_WORD;
    endfunction

    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] lo);
        return ((size == SZ_HALF) && lo[0]) || ((size == SZ_WORD) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_subword_ctrl_lane.sv
// Little-endian lane merge for sub-word stores and lane select/extend for loads.
module subword_lane
    import mips_mem_pkg::*;
(
    input  mem_size_t   size,
    input  logic [1:0]  lane,
    input  logic        bunsigned,
    input  logic [15:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] merged,
    output logic [31:0] loaded
);

    logic [7:0]  bsel;
    logic [15:0] hsel;
    logic [4:0]  boff;

    assign boff = {lane, 3'b000};

    always_comb begin
        merged = rdata;
        loaded = rdata;
        bsel   = rdata[boff +: 8];
        hsel   = lane[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: begin
                merged[boff +: 8] = wdata[7:0];
                loaded = {{24{~bunsigned & bsel[7]}}, bsel};
            end
            SZ_HALF: begin
                // Only lane[1] picks the halfword; lane[0] is ignored here.
                if (lane[1])
                    merged[31:16] = wdata;
                else
                    merged[15:0] = wdata;
                loaded = {{16{~bunsigned & hsel[15]}}, hsel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_subword_ctrl.sv
// MEM-stage data RAM controller: word stores direct, sub-word stores as RMW, loads as 2-cycle read.
// Optional MISALIGN_TRAP_EN adds a misalign output and blocks misaligned halfword/word accesses.
module mem_subword_ctrl
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memwrite,
    input  logic              memread,
    input  logic              half,
    input  logic              b,
    input  logic              bunsigned,
    input  logic [ADDR_W-1:0] dataadr,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              rdata_valid,
    output logic              stall,
    output logic [ADDR_W-3:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
`ifdef MISALIGN_TRAP_EN
    output logic              misalign,
`endif
    input  logic [31:0]       ram_rdata
);

    mem_state_t  state, state_nxt;
    mem_size_t   size;
    logic        bad;
    logic [31:0] merged, loaded;

    assign size     = decode_size(b, half);
    assign ram_addr = dataadr[ADDR_W-1:2];

`ifdef MISALIGN_TRAP_EN
    assign bad = (memwrite | memread) & is_misaligned(size, dataadr[1:0]);
`else
    assign bad = 1'b0;
`endif

    subword_lane u_lane (
        .size      (size),
        .lane      (dataadr[1:0]),
        .bunsigned (bunsigned),
        .wdata     (writedata[15:0]),
        .rdata     (ram_rdata),
        .merged    (merged),
        .loaded    (loaded)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        ram_we      = 1'b0;
        ram_wdata   = '0;
        stall       = 1'b0;
        rdata_valid = 1'b0;
`ifdef MISALIGN_TRAP_EN
        misalign    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bad) begin
`ifdef MISALIGN_TRAP_EN
                    misalign = 1'b1;
`endif
                end else if (memwrite) begin
                    if (size == SZ_WORD) begin
                        ram_we    = 1'b1;
                        ram_wdata = writedata;
                    end else begin
                        stall     = 1'b1;
                        state_nxt = RMW;
                    end
                end else if (memread) begin
                    stall     = 1'b1;
                    state_nxt = LOAD;
                end
            end
            RMW: begin
                ram_we    = 1'b1;
                ram_wdata = merged;
                state_nxt = IDLE;
            end
            LOAD: begin
                rdata_valid = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Reset masks every pipeline-visible strobe in the same cycle, aborting an RMW write.
        if (reset) begin
            ram_we      = 1'b0;
            stall       = 1'b0;
            rdata_valid = 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign    = 1'b0;
`endif
        end
        readdata = rdata_valid ? loaded : '0;
    end

endmodule

// File: tb/tb_mem_subword_ctrl.sv
// Randomized bench for mem_subword_ctrl against a byte-array memory model.
module tb_mem_subword_ctrl;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              memwrite, memread, half, b, bunsigned;
    logic [ADDR_W-1:0] dataadr;
    logic [31:0]       writedata, readdata, ram_wdata, ram_rdata;
    logic              rdata_valid, stall, ram_we;
    logic [ADDR_W-3:0] ram_addr;
`ifdef MISALIGN_TRAP_EN
    logic              misalign;
`endif

    // Bench-side RAM with a preload port, plus an independent byte-wide reference model.
    logic [31:0] ram [64];
    logic        pre_we;
    logic [5:0]  pre_idx;
    logic [31:0] pre_val;
    logic [7:0]  mdl [256];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_subword_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .memwrite    (memwrite),
        .memread     (memread),
        .half        (half),
        .b           (b),
        .bunsigned   (bunsigned),
        .dataadr     (dataadr),
        .writedata   (writedata),
        .readdata    (readdata),
        .rdata_valid (rdata_valid),
        .stall       (stall),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
`ifdef MISALIGN_TRAP_EN
        .misalign    (misalign),
`endif
        .ram_rdata   (ram_rdata)
    );

    always @(posedge clk) begin
        if (pre_we)
            ram[pre_idx] <= pre_val;
        else if (ram_we)
            ram[ram_addr[5:0]] <= ram_wdata;
        ram_rdata <= ram[ram_addr[5:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mword(input int idx);
        return {mdl[4*idx+3], mdl[4*idx+2], mdl[4*idx+1], mdl[4*idx]};
    endfunction

    // sz: 0 word, 1 halfword, 2 byte
    function automatic int base_of(input int sz, input int addr);
        if (sz == 2) return addr;
        if (sz == 1) return addr & 'hFE;
        return addr & 'hFC;
    endfunction

    function automatic logic [31:0] ref_load(input int sz, input int addr, input bit uns);
        int bs = base_of(sz, addr);
        logic [7:0]  v8  = mdl[bs];
        logic [15:0] v16 = {mdl[bs+1], mdl[bs]};
        if (sz == 2) return uns ? 32'(v8) : 32'($signed(v8));
        if (sz == 1) return uns ? 32'(v16) : 32'($signed(v16));
        return mword(bs / 4);
    endfunction

    task automatic ref_store(input int sz, input int addr, input logic [31:0] wd);
        int bs = base_of(sz, addr);
        int n  = (sz == 2) ? 1 : (sz == 1) ? 2 : 4;
        for (int i = 0; i < n; i++)
            mdl[bs+i] = wd[8*i +: 8];
    endtask

    task automatic drive(input bit wr, input bit rd, input int sz, input int addr,
                         input logic [31:0] wd, input bit uns);
        memwrite  = wr;
        memread   = rd;
        half      = (sz == 1);
        b         = (sz == 2);
        bunsigned = uns;
        dataadr   = ADDR_W'(addr);
        writedata = wd;
    endtask

    task automatic set_word(input int idx, input logic [31:0] val);
        drive(0, 0, 0, 0, '0, 0);
        pre_we  = 1'b1;
        pre_idx = 6'(idx);
        pre_val = val;
        for (int i = 0; i < 4; i++)
            mdl[4*idx+i] = val[8*i +: 8];
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic idle_cycle();
        drive(0, 0, 0, 0, '0, 0);
        @(negedge clk);
        check("idle_stall", stall, 0);
        check("idle_we", ram_we, 0);
        check("idle_valid", rdata_valid, 0);
        check("idle_rdata", readdata, 0);
        @(posedge clk); #1;
    endtask

    // Called at posedge+1; returns at posedge+1 with the request still applied.
    task automatic run_op(input bit is_store, input bit also_rd, input int sz, input int addr,
                          input logic [31:0] wd, input bit uns);
        int widx = base_of(sz, addr) / 4;
        logic [31:0] exp_ld;
        drive(is_store, is_store ? also_rd : 1'b1, sz, addr, wd, uns);
        exp_ld = ref_load(sz, addr, uns);
        @(negedge clk);
        check("ram_addr", 32'(ram_addr), 32'(addr >> 2));
        check("c1_valid", rdata_valid, 0);
        if (is_store && sz == 0) begin
            ref_store(sz, addr, wd);
            check("sw_stall", stall, 0);
            check("sw_we", ram_we, 1);
            check("sw_wdata", ram_wdata, wd);
            @(posedge clk); #1;
            check("sw_ram", ram[widx], mword(widx));
            return;
        end
        check("c1_stall", stall, 1);
        check("c1_we", ram_we, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("c2_stall", stall, 0);
        if (is_store) begin
            ref_store(sz, addr, wd);
            check("rmw_we", ram_we, 1);
            check("rmw_wdata", ram_wdata, mword(widx));
            check("rmw_valid", rdata_valid, 0);
            @(posedge clk); #1;
            check("rmw_ram", ram[widx], mword(widx));
        end else begin
            check("ld_valid", rdata_valid, 1);
            check("ld_data", readdata, exp_ld);
            check("ld_we", ram_we, 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset  = 1'b1;
        pre_we = 1'b0;
        drive(0, 1, 0, 0, '0, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_stall", stall, 0);
        check("rst_we", ram_we, 0);
        check("rst_valid", rdata_valid, 0);
        check("rst_rdata", readdata, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 64; i++)
            set_word(i, $urandom);
        reset = 1'b0;
        idle_cycle();

        // Directed cases from the feature list.
        set_word(20, 32'h12345678);
        run_op(1, 0, 1, 80, 32'h0000FFFF, 0);
        check("sh_tp", ram[20], 32'h1234FFFF);
        set_word(20, 32'h12345678);
        run_op(1, 0, 2, 83, 32'h000000AB, 0);
        check("sb_tp", ram[20], 32'hAB345678);
        set_word(20, 32'h0080FF00);
        run_op(0, 0, 2, 82, '0, 0);
        run_op(0, 0, 2, 82, '0, 1);
        idle_cycle();
        run_op(1, 0, 0, 84, 32'hDEADBEEF, 0);
        check("sw_tp", ram[21], 32'hDEADBEEF);
        idle_cycle();

        // Reset during RMW: write aborted, state back to IDLE.
        set_word(22, 32'hCAFEF00D);
        drive(1, 0, 1, 88, 32'h00001111, 0);
        @(negedge clk);
        check("rr_c1_stall", stall, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rr_we", ram_we, 0);
        check("rr_stall", stall, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(0, 0, 0, 0, '0, 0);
        check("rr_ram", ram[22], 32'hCAFEF00D);
        idle_cycle();

        // Reset during LOAD: no valid strobe.
        drive(0, 1, 0, 88, '0, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rl_valid", rdata_valid, 0);
        check("rl_rdata", readdata, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle_cycle();

`ifdef MISALIGN_TRAP_EN
        drive(0, 1, 1, 81, '0, 0);
        @(negedge clk);
        check("mis_flag", misalign, 1);
        check("mis_we", ram_we, 0);
        check("mis_stall", stall, 0);
        @(posedge clk); #1;
        idle_cycle();
`endif

        // Random traffic, mostly back-to-back, with write-over-read priority mixed in.
        for (int n = 0; n < 400; n++) begin
            int sz   = $urandom_range(0, 2);
            int addr = $urandom_range(0, 255);
`ifdef MISALIGN_TRAP_EN
            addr = base_of(sz, addr);
`endif
            if ($urandom_range(0, 4) == 0)
                idle_cycle();
            run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz, addr,
                   $urandom, 1'($urandom_range(0, 1)));
        end
        idle_cycle();

        for (int i = 0; i < 64; i++)
            check("final_mem", ram[i], mword(i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
